// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Purpose : Shared types and constants for the instruction-memory responder.
//           Holds the responder FSM state type, the NOP returned on error
//           requests, and the default geometry/latency values.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_t;

  localparam logic [15:0] NOP_INSTR       = 16'h0800;
  localparam int          DEFAULT_LATENCY = 3;
  localparam int          DEFAULT_DEPTH   = 1024;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Purpose : DEPTH x 16-bit program storage, synchronous write, combinational
//           read. Indices are word indices (byte address bits [AW:1]).
// Ports   : clk      - clock
//           i_we     - write strobe
//           i_waddr  - write word index
//           i_wdata  - write data
//           i_raddr  - read word index
//           o_rdata  - read data (combinational)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  // Contents survive reset on purpose: a reset must not wipe a loaded program.
  logic [15:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : imem_responder
// Purpose : Responder end of the instruction-fetch interface. Accepts fetch
//           requests, returns the 16-bit word LATENCY cycles after accept,
//           supports flush of an in-flight fetch, and a side program-load
//           port that writes only while idle.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           req_valid/req_addr/req_ready        - request handshake
//           flush                    - cancel in-flight or pending response
//           resp_valid/resp_ready    - response handshake
//           resp_instr/resp_addr/resp_err       - response payload
//           ld_en/ld_addr/ld_data/ld_ack        - program-load port
//           stat_served              - consumed-response counter
// Options : IMEM_STATS_EN - when defined, stat_served is a saturating count of
//           consumed responses; otherwise it is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_instr,
  output logic [15:0] resp_addr,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  output logic [15:0] stat_served
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] c_DEPTH16  = 16'(DEPTH);
  localparam logic [3:0]  c_LAT_M1   = 4'(LATENCY - 1);

  imem_state_t r_state;
  imem_state_t w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_instr;
  logic        r_err;
  logic        r_ld_ack;

  logic        w_accept;
  logic        w_capture;
  logic        w_ld_ok;
  logic        w_ld_write;
  logic [15:0] w_rd_addr;
  logic        w_rd_err;
  logic [15:0] w_rdata;

  // With LATENCY=1 the read happens on the accept edge itself, so the read
  // address comes straight from the request port while idle.
  assign w_rd_addr  = (r_state == ST_IDLE) ? req_addr : r_addr;
  assign w_rd_err   = w_rd_addr[0] | ({1'b0, w_rd_addr[15:1]} >= c_DEPTH16);

  assign w_ld_ok    = ~ld_addr[0] & ({1'b0, ld_addr[15:1]} < c_DEPTH16);
  assign w_ld_write = ~rst & (r_state == ST_IDLE) & ld_en & w_ld_ok;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ld_write),
    .i_waddr (ld_addr[AW:1]),
    .i_wdata (ld_data),
    .i_raddr (w_rd_addr[AW:1]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A load in the same cycle wins over a request.
        req_ready = ~flush & ~ld_en;
        if (req_valid & ~flush & ~ld_en) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next    = ST_RESP;
            w_capture = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          w_next = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next    = ST_RESP;
          w_capture = 1'b1;
        end
      end
      ST_RESP: begin
        // flush beats resp_ready: the response is dropped, not consumed.
        if (flush | resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_addr   <= 16'h0000;
      r_instr  <= 16'h0000;
      r_err    <= 1'b0;
      r_ld_ack <= 1'b0;
    end else begin
      r_ld_ack <= w_ld_write;
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= c_LAT_M1;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_instr <= w_rd_err ? NOP_INSTR : w_rdata;
        r_err   <= w_rd_err;
      end
    end
  end

  assign resp_valid = (r_state == ST_RESP);
  assign resp_instr = r_instr;
  assign resp_addr  = r_addr;
  assign resp_err   = r_err;
  assign ld_ack     = r_ld_ack;

`ifdef IMEM_STATS_EN
  logic        w_consume;
  logic [15:0] r_served;

  assign w_consume = (r_state == ST_RESP) & resp_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_served <= 16'h0000;
    end else if (w_consume && (r_served != 16'hFFFF)) begin
      r_served <= r_served + 16'd1;
    end
  end

  assign stat_served = r_served;
`else
  assign stat_served = 16'h0000;
`endif

endmodule
`default_nettype wire
